// File: rtl/uart_out_tx.sv
// Captures CPU output bytes on outFlag rising edges, queues them, and sends them as 8N1 UART frames.
// Defining UART_PARITY_EN inserts an even-parity bit before the stop bit.
module uart_out_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 16,
  parameter int DATAWIDTH    = 8
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          outFlag,
  input  logic                          endFlag,
  input  logic [DATAWIDTH-1:0]          dataIn,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifoCount,
  output logic                          overflow,
  output logic                          done
);

  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = $clog2(FIFO_DEPTH) + 1;
  localparam int BCW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IW  = (DATAWIDTH > 1) ? $clog2(DATAWIDTH) : 1;
  localparam logic [BCW-1:0] BAUD_LAST = BCW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0]  IDX_LAST  = IW'(DATAWIDTH - 1);
  localparam logic [CW-1:0]  FULL_CNT  = CW'(FIFO_DEPTH);

`ifdef UART_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  logic                 outS1_q, outS2_q, outH_q;
  logic                 endS1_q, endS2_q, endH_q;
  logic                 endSeen_q;
  logic [DATAWIDTH-1:0] fifoMem_q [FIFO_DEPTH];
  logic [AW-1:0]        wrPtr_q, rdPtr_q;
  logic [CW-1:0]        count_q, count_d;
  state_t               state_q, state_d;
  logic [BCW-1:0]       baud_q, baud_d;
  logic [IW-1:0]        bitIdx_q, bitIdx_d;
  logic [DATAWIDTH-1:0] shift_q, shift_d;
  logic                 tx_q, tx_d;
  logic                 overflow_q, done_q;
`ifdef UART_PARITY_EN
  logic [DATAWIDTH-1:0] frame_q, frame_d;
`endif

  logic push, pushOk, pop, full, empty, endRise, ovfSet, baudLast;

  // Flops reset high so a flag already asserted across reset never looks like an edge.
  assign push     = outS2_q & ~outH_q;
  assign endRise  = endS2_q & ~endH_q;
  assign full     = (count_q == FULL_CNT);
  assign empty    = (count_q == '0);
  assign pushOk   = push & (~full | pop);
  assign ovfSet   = push & full & ~pop;
  assign baudLast = (baud_q == BAUD_LAST);

  always_comb begin
    count_d = count_q;
    if (pushOk && !pop)      count_d = count_q + CW'(1);
    else if (!pushOk && pop) count_d = count_q - CW'(1);
  end

  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q + BCW'(1);
    bitIdx_d = bitIdx_q;
    shift_d  = shift_q;
    tx_d     = tx_q;
    pop      = 1'b0;
`ifdef UART_PARITY_EN
    frame_d  = frame_q;
`endif
    case (state_q)
      IDLE: begin
        baud_d = '0;
        tx_d   = 1'b1;
        if (!empty) begin
          pop     = 1'b1;
          shift_d = fifoMem_q[rdPtr_q];
`ifdef UART_PARITY_EN
          frame_d = fifoMem_q[rdPtr_q];
`endif
          tx_d    = 1'b0;
          state_d = START;
        end
      end
      START: begin
        if (baudLast) begin
          baud_d   = '0;
          bitIdx_d = '0;
          tx_d     = shift_q[0];
          state_d  = DATA;
        end
      end
      DATA: begin
        if (baudLast) begin
          baud_d = '0;
          if (bitIdx_q == IDX_LAST) begin
`ifdef UART_PARITY_EN
            tx_d    = ^frame_q;
            state_d = PARITY;
`else
            tx_d    = 1'b1;
            state_d = STOP;
`endif
          end else begin
            shift_d  = shift_q >> 1;
            tx_d     = shift_d[0];
            bitIdx_d = bitIdx_q + IW'(1);
          end
        end
      end
`ifdef UART_PARITY_EN
      PARITY: begin
        if (baudLast) begin
          baud_d  = '0;
          tx_d    = 1'b1;
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        if (baudLast) begin
          baud_d = '0;
          // Pop straight into the next start bit so queued frames run with no idle gap.
          if (!empty) begin
            pop     = 1'b1;
            shift_d = fifoMem_q[rdPtr_q];
`ifdef UART_PARITY_EN
            frame_d = fifoMem_q[rdPtr_q];
`endif
            tx_d    = 1'b0;
            state_d = START;
          end else begin
            tx_d    = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (pushOk) fifoMem_q[wrPtr_q] <= dataIn;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      outS1_q    <= 1'b1;
      outS2_q    <= 1'b1;
      outH_q     <= 1'b1;
      endS1_q    <= 1'b1;
      endS2_q    <= 1'b1;
      endH_q     <= 1'b1;
      endSeen_q  <= 1'b0;
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      count_q    <= '0;
      state_q    <= IDLE;
      baud_q     <= '0;
      bitIdx_q   <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
`ifdef UART_PARITY_EN
      frame_q    <= '0;
`endif
    end else begin
      outS1_q    <= outFlag;
      outS2_q    <= outS1_q;
      outH_q     <= outS2_q;
      endS1_q    <= endFlag;
      endS2_q    <= endS1_q;
      endH_q     <= endS2_q;
      endSeen_q  <= endSeen_q | endRise;
      if (pushOk) wrPtr_q <= wrPtr_q + AW'(1);
      if (pop)    rdPtr_q <= rdPtr_q + AW'(1);
      count_q    <= count_d;
      state_q    <= state_d;
      baud_q     <= baud_d;
      bitIdx_q   <= bitIdx_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      overflow_q <= overflow_q | ovfSet;
      done_q     <= done_q | (endSeen_q & (state_q == IDLE) & empty);
`ifdef UART_PARITY_EN
      frame_q    <= frame_d;
`endif
    end
  end

  assign tx        = tx_q;
  assign busy      = (state_q != IDLE);
  assign fifoCount = count_q;
  assign overflow  = overflow_q;
  assign done      = done_q;

endmodule

// File: tb/tb_uart_out_tx.sv
// Scoreboard bench for uart_out_tx: a tx-line monitor decodes frames, tests compare against queued expectations.
module tb_uart_out_tx;

  localparam int CPB = 4;
  localparam int DEPTH = 4;
`ifdef UART_PARITY_EN
  localparam bit PAR = 1'b1;
  localparam int FRAME = 11 * CPB;
`else
  localparam bit PAR = 1'b0;
  localparam int FRAME = 10 * CPB;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       outFlag = 1'b0;
  logic       endFlag = 1'b0;
  logic [7:0] dataIn = '0;
  logic       tx, busy, overflow, done;
  logic [2:0] fifoCount;

  uart_out_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .DATAWIDTH(8)) dut (
    .clock(clock), .reset(reset), .outFlag(outFlag), .endFlag(endFlag),
    .dataIn(dataIn), .tx(tx), .busy(busy), .fifoCount(fifoCount),
    .overflow(overflow), .done(done)
  );

  always #10 clock = ~clock;

  typedef struct {
    logic [7:0] data;
    bit         start_ok;
    bit         stop_ok;
    logic       par;
    int         start_cyc;
  } frame_t;

  frame_t     rxq[$];
  logic [7:0] expq[$];
  int         tests = 0;
  int         fails = 0;
  int         cyc = 0;
  int         max_cnt = 0;

  always @(posedge clock) cyc++;
  always @(negedge clock) if (int'(fifoCount) > max_cnt) max_cnt = int'(fifoCount);

  // Frame decoder: samples each bit at its centre, starting from the first low cycle.
  always begin : monitor
    frame_t f;
    @(negedge clock);
    if (tx === 1'b0) begin
      f.start_cyc = cyc;
      repeat (CPB / 2) @(negedge clock);
      f.start_ok = (tx === 1'b0);
      for (int i = 0; i < 8; i++) begin
        repeat (CPB) @(negedge clock);
        f.data[i] = tx;
      end
      if (PAR) begin
        repeat (CPB) @(negedge clock);
        f.par = tx;
      end else begin
        f.par = ^f.data;
      end
      repeat (CPB) @(negedge clock);
      f.stop_ok = (tx === 1'b1);
      repeat (CPB - CPB / 2 - 1) @(negedge clock);
      rxq.push_back(f);
    end
  end

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    outFlag = 1'b0;
    endFlag = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    rxq.delete();
    expq.delete();
  endtask

  task automatic pulse(input logic [7:0] b, input int hi, input int lo, input bit accept);
    @(negedge clock);
    dataIn = b;
    outFlag = 1'b1;
    if (accept) expq.push_back(b);
    repeat (hi) @(negedge clock);
    outFlag = 1'b0;
    repeat (lo - 1) @(negedge clock);
  endtask

  task automatic wait_frames(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (rxq.size() >= n) break;
      @(negedge clock);
    end
    ok = (rxq.size() >= n);
  endtask

  task automatic test_reset();
    do_reset();
    tests++; if (tx !== 1'b1)       begin fails++; $display("FAIL reset_tx got %b want 1", tx); end
    tests++; if (busy !== 1'b0)     begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
    tests++; if (fifoCount !== 3'd0) begin fails++; $display("FAIL reset_count got %0d want 0", fifoCount); end
    tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL reset_overflow got %b want 0", overflow); end
    tests++; if (done !== 1'b0)     begin fails++; $display("FAIL reset_done got %b want 0", done); end
  endtask

  task automatic test_single();
    frame_t f;
    logic [7:0] e;
    bit ok;
    do_reset();
    @(negedge clock);
    dataIn = 8'hA5;
    outFlag = 1'b1;
    expq.push_back(8'hA5);
    @(negedge clock); // after E0
    tests++; if (fifoCount !== 3'd0) begin fails++; $display("FAIL single_cnt_e0 got %0d want 0", fifoCount); end
    @(negedge clock); // after E1
    tests++; if (fifoCount !== 3'd0) begin fails++; $display("FAIL single_cnt_e1 got %0d want 0", fifoCount); end
    @(negedge clock); // after E2
    tests++; if (fifoCount !== 3'd1 || tx !== 1'b1) begin fails++; $display("FAIL single_push_e2 cnt=%0d tx=%b want cnt=1 tx=1", fifoCount, tx); end
    @(negedge clock); // after E3
    tests++; if (tx !== 1'b0 || busy !== 1'b1) begin fails++; $display("FAIL single_start_e3 tx=%b busy=%b want tx=0 busy=1", tx, busy); end
    outFlag = 1'b0;
    wait_frames(1, 3 * FRAME, ok);
    tests++; if (!ok) begin fails++; $display("FAIL single_timeout got %0d frames want 1", rxq.size()); end
    while (rxq.size() > 0 && expq.size() > 0) begin
      f = rxq.pop_front(); e = expq.pop_front();
      tests++;
      if (f.data !== e || !f.start_ok || !f.stop_ok || f.par !== ^e) begin
        fails++; $display("FAIL single_frame got %h s%0d p%b t%0d want %h s1 p%b t1", f.data, f.start_ok, f.par, f.stop_ok, e, ^e);
      end
    end
    repeat (3) @(negedge clock);
    tests++; if (busy !== 1'b0 || tx !== 1'b1) begin fails++; $display("FAIL single_idle busy=%b tx=%b want busy=0 tx=1", busy, tx); end
  endtask

  task automatic test_back_to_back();
    frame_t f[3];
    logic [7:0] e;
    bit ok;
    do_reset();
    max_cnt = 0;
    pulse(8'h01, 4, 4, 1'b1);
    pulse(8'h02, 4, 4, 1'b1);
    pulse(8'h03, 4, 4, 1'b1);
    wait_frames(3, 6 * FRAME, ok);
    tests++; if (!ok) begin fails++; $display("FAIL b2b_timeout got %0d frames want 3", rxq.size()); end
    for (int i = 0; i < 3; i++) begin
      if (rxq.size() > 0 && expq.size() > 0) begin
        f[i] = rxq.pop_front(); e = expq.pop_front();
        tests++;
        if (f[i].data !== e || !f[i].start_ok || !f[i].stop_ok || f[i].par !== ^e) begin
          fails++; $display("FAIL b2b_frame%0d got %h want %h", i, f[i].data, e);
        end
      end
    end
    if (ok) begin
      tests++; if (f[1].start_cyc - f[0].start_cyc != FRAME) begin fails++; $display("FAIL b2b_gap01 got %0d want %0d", f[1].start_cyc - f[0].start_cyc, FRAME); end
      tests++; if (f[2].start_cyc - f[1].start_cyc != FRAME) begin fails++; $display("FAIL b2b_gap12 got %0d want %0d", f[2].start_cyc - f[1].start_cyc, FRAME); end
    end
    tests++; if (max_cnt != 2) begin fails++; $display("FAIL b2b_maxcount got %0d want 2", max_cnt); end
    tests++; if (fifoCount !== 3'd0) begin fails++; $display("FAIL b2b_endcount got %0d want 0", fifoCount); end
  endtask

  task automatic test_overflow();
    frame_t f;
    logic [7:0] e;
    bit ok;
    do_reset();
    pulse(8'hC3, 3, 2, 1'b1);
    for (int i = 0; i < 6; i++) pulse(8'h10 + 8'(i), 3, 2, i < DEPTH);
    repeat (2) @(negedge clock);
    tests++; if (fifoCount !== 3'(DEPTH)) begin fails++; $display("FAIL ovf_count got %0d want %0d", fifoCount, DEPTH); end
    tests++; if (overflow !== 1'b1) begin fails++; $display("FAIL ovf_flag got %b want 1", overflow); end
    wait_frames(5, 8 * FRAME, ok);
    tests++; if (!ok) begin fails++; $display("FAIL ovf_timeout got %0d frames want 5", rxq.size()); end
    while (rxq.size() > 0 && expq.size() > 0) begin
      f = rxq.pop_front(); e = expq.pop_front();
      tests++;
      if (f.data !== e || !f.start_ok || !f.stop_ok || f.par !== ^e) begin
        fails++; $display("FAIL ovf_frame got %h want %h", f.data, e);
      end
    end
    repeat (2 * FRAME) @(negedge clock);
    tests++; if (rxq.size() != 0) begin fails++; $display("FAIL ovf_extra_frames got %0d want 0", rxq.size()); end
    tests++; if (overflow !== 1'b1) begin fails++; $display("FAIL ovf_sticky got %b want 1", overflow); end
  endtask

  task automatic test_reset_midframe();
    int lows;
    bit seen;
    do_reset();
    pulse(8'h3C, 3, 2, 1'b0);
    @(negedge clock);
    dataIn = 8'h77;
    outFlag = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (tx === 1'b0) begin seen = 1'b1; break; end
      @(negedge clock);
    end
    tests++; if (!seen) begin fails++; $display("FAIL rstmid_nostart got tx=%b want 0", tx); end
    repeat (17) @(negedge clock); // inside DATA bit 3
    reset = 1'b1;
    @(negedge clock);
    tests++; if (tx !== 1'b1 || busy !== 1'b0 || fifoCount !== 3'd0) begin
      fails++; $display("FAIL rstmid_abort tx=%b busy=%b cnt=%0d want 1 0 0", tx, busy, fifoCount);
    end
    @(negedge clock);
    reset = 1'b0;
    lows = 0;
    repeat (3 * FRAME) begin
      @(negedge clock);
      if (tx !== 1'b1) lows++;
    end
    tests++; if (lows != 0 || busy !== 1'b0) begin fails++; $display("FAIL rstmid_noframe lows=%0d busy=%b want 0 0", lows, busy); end
    outFlag = 1'b0;
    rxq.delete();
  endtask

  task automatic test_done();
    frame_t f;
    logic [7:0] e;
    int early, budget;
    bit seen;
    do_reset();
    pulse(8'hA1, 3, 2, 1'b1);
    pulse(8'hB2, 3, 2, 1'b1);
    pulse(8'hC4, 3, 2, 1'b1);
    @(negedge clock);
    tests++; if (fifoCount !== 3'd2) begin fails++; $display("FAIL done_queued got %0d want 2", fifoCount); end
    endFlag = 1'b1;
    early = 0;
    seen = 1'b0;
    budget = 5 * FRAME;
    while (budget > 0 && !seen) begin
      @(negedge clock);
      budget--;
      if (busy === 1'b0) seen = 1'b1;
      else if (done !== 1'b0) early++;
    end
    tests++; if (!seen) begin fails++; $display("FAIL done_timeout busy=%b want 0", busy); end
    tests++; if (early != 0 || done !== 1'b0) begin fails++; $display("FAIL done_early early=%0d done=%b want 0 0", early, done); end
    @(negedge clock);
    tests++; if (done !== 1'b1) begin fails++; $display("FAIL done_set got %b want 1", done); end
    pulse(8'h5E, 3, 2, 1'b1);
    early = 0;
    repeat (2 * FRAME) begin
      @(negedge clock);
      if (done !== 1'b1) early++;
    end
    tests++; if (early != 0) begin fails++; $display("FAIL done_sticky drops=%0d want 0", early); end
    tests++; if (rxq.size() != 4) begin fails++; $display("FAIL done_frames got %0d want 4", rxq.size()); end
    while (rxq.size() > 0 && expq.size() > 0) begin
      f = rxq.pop_front(); e = expq.pop_front();
      tests++;
      if (f.data !== e || !f.start_ok || !f.stop_ok || f.par !== ^e) begin
        fails++; $display("FAIL done_frame got %h want %h", f.data, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_reset_midframe();
    test_done();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
